// File: rtl/bus_rr_arbiter_if.sv
// Shared-bus arbitration interface: per-device requests and data/control slices in,
// one-hot grant, muxed shared bus and ownership status out.
interface bus_rr_arbiter_if #(
  parameter int NUM_DEVICES = 8,
  parameter int D_WIDTH     = 32,
  parameter int C_WIDTH     = 8
);
  localparam int OW = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;

  logic [NUM_DEVICES-1:0]         req;
  logic [NUM_DEVICES-1:0]         ack;
  logic [NUM_DEVICES*D_WIDTH-1:0] bus_in;
  logic [NUM_DEVICES*C_WIDTH-1:0] ctrl_in;
  logic [D_WIDTH-1:0]             bus_out;
  logic [C_WIDTH-1:0]             ctrl_out;
  logic [OW-1:0]                  owner;
  logic                           owner_valid;
  logic                           timeout_err;

  // Requesters drive requests and their bus slices; they observe the grant.
  modport master (
    output req, bus_in, ctrl_in,
    input  ack, bus_out, ctrl_out, owner, owner_valid, timeout_err
  );

  // The arbiter samples requests and drives grant and shared bus.
  modport slave (
    input  req, bus_in, ctrl_in,
    output ack, bus_out, ctrl_out, owner, owner_valid, timeout_err
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin shared-bus arbiter with a one-cycle TURN gap between grants.
// Define BUS_ARB_TIMEOUT_EN to bound each grant to HOLD_MAX cycles (timeout_err pulse on forced release).
module bus_rr_arbiter #(
  parameter int NUM_DEVICES = 8,
  parameter int D_WIDTH     = 32,
  parameter int C_WIDTH     = 8,
  parameter int HOLD_MAX    = 256
) (
  input logic             clk,
  input logic             reset,
  bus_rr_arbiter_if.slave arb
);
  localparam int OW = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;

  if (NUM_DEVICES < 2 || HOLD_MAX < 1) begin : g_bad_params
    $error("bus_rr_arbiter: NUM_DEVICES must be >= 2 and HOLD_MAX >= 1");
  end

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t                 state_reg, state_next;
  logic [OW-1:0]          owner_reg, owner_next;
  logic [OW-1:0]          last_reg, last_next;
  logic [NUM_DEVICES-1:0] ack_reg, ack_next;
  logic                   owner_valid_reg, owner_valid_next;

  logic [OW-1:0]          pick;
  logic [NUM_DEVICES-1:0] pick_onehot;
  logic                   any_req;
  logic                   hold_limit;

  logic [D_WIDTH-1:0]     data_slice [NUM_DEVICES];
  logic [C_WIDTH-1:0]     ctrl_slice [NUM_DEVICES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEVICES; gi++) begin : g_dev
      assign data_slice[gi]  = arb.bus_in[gi*D_WIDTH +: D_WIDTH];
      assign ctrl_slice[gi]  = arb.ctrl_in[gi*C_WIDTH +: C_WIDTH];
      assign pick_onehot[gi] = (pick == OW'(gi));
    end
  endgenerate

  assign any_req = |arb.req;

  // Walk downward so the last hit is the nearest requester above last_reg.
  always_comb begin
    pick = '0;
    for (int off = NUM_DEVICES; off >= 1; off--) begin
      if (arb.req[OW'((int'(last_reg) + off) % NUM_DEVICES)])
        pick = OW'((int'(last_reg) + off) % NUM_DEVICES);
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  logic          timeout_reg, timeout_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  // Counts cycles spent in GRANT; cleared in any other state so a new grant starts at 0.
  always_comb begin
    hold_cnt_next = hold_cnt_reg + HW'(1);
    if (state_reg != GRANT)
      hold_cnt_next = '0;
  end

  assign hold_limit   = (state_reg == GRANT) && (hold_cnt_reg == HW'(HOLD_MAX - 1));
  // A requester dropping on the limit cycle is an ordinary release, not a timeout.
  assign timeout_next = hold_limit && arb.req[owner_reg];
  assign arb.timeout_err = timeout_reg;
`else
  assign hold_limit      = 1'b0;
  assign arb.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      owner_reg       <= '0;
      last_reg        <= OW'(NUM_DEVICES - 1);
      ack_reg         <= '0;
      owner_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      last_reg        <= last_next;
      ack_reg         <= ack_next;
      owner_valid_reg <= owner_valid_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    last_next        = last_reg;
    ack_next         = ack_reg;
    owner_valid_next = owner_valid_reg;
    unique case (state_reg)
      IDLE, TURN: begin
        if (any_req) begin
          state_next       = GRANT;
          owner_next       = pick;
          last_next        = pick;
          ack_next         = pick_onehot;
          owner_valid_next = 1'b1;
        end else begin
          state_next       = IDLE;
          ack_next         = '0;
          owner_valid_next = 1'b0;
        end
      end
      GRANT: begin
        // Only the owner's request matters while granted.
        if (!arb.req[owner_reg] || hold_limit) begin
          state_next       = TURN;
          ack_next         = '0;
          owner_valid_next = 1'b0;
        end
      end
      default: begin
        state_next       = IDLE;
        ack_next         = '0;
        owner_valid_next = 1'b0;
      end
    endcase
  end

  always_comb begin
    arb.bus_out  = '0;
    arb.ctrl_out = '0;
    if (owner_valid_reg) begin
      arb.bus_out  = data_slice[owner_reg];
      arb.ctrl_out = ctrl_slice[owner_reg];
    end
  end

  assign arb.ack         = ack_reg;
  assign arb.owner       = owner_reg;
  assign arb.owner_valid = owner_valid_reg;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed scenarios plus randomized requests
// checked against a cycle-level round-robin reference model.
module tb_bus_rr_arbiter;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int HM = 4;
  localparam int OW = $clog2(N);
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_rr_arbiter_if #(.NUM_DEVICES(N), .D_WIDTH(DW), .C_WIDTH(CW)) bus ();

  bus_rr_arbiter #(.NUM_DEVICES(N), .D_WIDTH(DW), .C_WIDTH(CW), .HOLD_MAX(HM)) dut (
    .clk  (clk),
    .reset(reset),
    .arb  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: is a grant active, who holds it, who was granted last,
  // how many edges the grant has lasted, and whether this cycle is a forced release.
  int m_busy, m_owner, m_last, m_hold, m_tout;

  function automatic int rr_pick(logic [N-1:0] r, int last);
    for (int off = 1; off <= N; off++) begin
      if (r[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_id(logic [N-1:0] v);
    for (int d = 0; d < N; d++) if (v[d]) return d;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ack();
    logic [N-1:0] v;
    v = '0;
    if (m_busy != 0) v[m_owner] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_bus();
    return (m_busy != 0) ? bus.bus_in[m_owner*DW +: DW] : '0;
  endfunction

  function automatic logic [CW-1:0] exp_ctrl();
    return (m_busy != 0) ? bus.ctrl_in[m_owner*CW +: CW] : '0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = N - 1; m_hold = 0; m_tout = 0;
  endtask

  task automatic model_tick(logic [N-1:0] r);
    m_tout = 0;
    if (m_busy == 0) begin
      if (r != '0) begin
        m_owner = rr_pick(r, m_last);
        m_last  = m_owner;
        m_busy  = 1;
        m_hold  = 0;
      end
    end else if (!r[m_owner]) begin
      m_busy = 0;
    end else if (TIMEOUT_ON && m_hold == HM - 1) begin
      m_busy = 0;
      m_tout = 1;
    end else begin
      m_hold++;
    end
  endtask

  task automatic randomize_buses();
    for (int d = 0; d < N; d++) begin
      bus.bus_in[d*DW +: DW]  = $urandom;
      bus.ctrl_in[d*CW +: CW] = CW'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick(bus.req);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    bus.req = '0;
    randomize_buses();
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.ack !== '0) begin n_fail++; $display("FAIL reset_ack got=%b want=0", bus.ack); end
    n_checks++; if (bus.owner !== '0) begin n_fail++; $display("FAIL reset_owner got=%0d want=0", bus.owner); end
    n_checks++; if (bus.owner_valid !== 1'b0) begin n_fail++; $display("FAIL reset_owner_valid got=%b want=0", bus.owner_valid); end
    n_checks++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b want=0", bus.timeout_err); end
    n_checks++; if (bus.bus_out !== '0) begin n_fail++; $display("FAIL reset_bus_out got=%h want=0", bus.bus_out); end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    bus.req = 8'b0000_0001;
    step();
    n_checks++; if (bus.ack !== 8'b0000_0001) begin n_fail++; $display("FAIL single_ack got=%b want=00000001", bus.ack); end
    n_checks++; if (bus.owner !== 3'd0 || bus.owner_valid !== 1'b1) begin n_fail++; $display("FAIL single_owner got=%0d/%b want=0/1", bus.owner, bus.owner_valid); end
    n_checks++; if (bus.bus_out !== bus.bus_in[0 +: DW]) begin n_fail++; $display("FAIL single_bus got=%h want=%h", bus.bus_out, bus.bus_in[0 +: DW]); end
    bus.req = '0;
    step();
    n_checks++; if (bus.ack !== '0 || bus.owner_valid !== 1'b0) begin n_fail++; $display("FAIL single_turn ack=%b valid=%b want 0/0", bus.ack, bus.owner_valid); end
    step();
    $display("test_single done");
  endtask

  task automatic test_rotation();
    logic [N-1:0] r, prev_ack;
    int seq[$];
    int gap;
    pulse_reset();
    prev_ack = '0;
    gap = 0;
    for (int c = 0; c < 120 && seq.size() < N + 1; c++) begin
      r = '1;
      if (m_busy != 0 && m_hold >= 2) r[m_owner] = 1'b0;
      bus.req = r;
      step();
      n_checks++; if (bus.ack !== exp_ack()) begin n_fail++; $display("FAIL rot_ack cyc=%0d got=%b want=%b", c, bus.ack, exp_ack()); end
      if (bus.ack == '0) begin
        gap++;
      end else if (prev_ack == '0) begin
        seq.push_back(onehot_id(bus.ack));
        if (seq.size() > 1) begin
          n_checks++; if (gap != 1) begin n_fail++; $display("FAIL rot_gap grant#%0d got=%0d want=1", seq.size() - 1, gap); end
        end
        gap = 0;
      end
      prev_ack = bus.ack;
    end
    n_checks++; if (seq.size() != N + 1) begin n_fail++; $display("FAIL rot_count got=%0d want=%0d", seq.size(), N + 1); end
    for (int i = 0; i < seq.size(); i++) begin
      n_checks++; if (seq[i] != i % N) begin n_fail++; $display("FAIL rot_order idx=%0d got=%0d want=%0d", i, seq[i], i % N); end
    end
    bus.req = '0;
    repeat (2) step();
    $display("test_rotation done grants=%0d", seq.size());
  endtask

  task automatic test_wrap();
    pulse_reset();
    bus.req = 8'h40;
    step();
    n_checks++; if (bus.ack !== 8'h40) begin n_fail++; $display("FAIL wrap_own6 got=%b want=01000000", bus.ack); end
    bus.req = 8'hC4;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (bus.ack !== 8'h40 || bus.owner !== 3'd6) begin n_fail++; $display("FAIL wrap_hold6 i=%0d ack=%b owner=%0d want 01000000/6", i, bus.ack, bus.owner); end
    end
    bus.req = 8'h84;
    step();
    n_checks++; if (bus.ack !== '0 || bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL wrap_turn1 ack=%b tout=%b want 0/0", bus.ack, bus.timeout_err); end
    step();
    n_checks++; if (bus.ack !== 8'h80 || bus.owner !== 3'd7) begin n_fail++; $display("FAIL wrap_own7 ack=%b owner=%0d want 10000000/7", bus.ack, bus.owner); end
    bus.req = 8'h04;
    step();
    n_checks++; if (bus.ack !== '0) begin n_fail++; $display("FAIL wrap_turn2 got=%b want=0", bus.ack); end
    step();
    n_checks++; if (bus.ack !== 8'h04 || bus.owner !== 3'd2) begin n_fail++; $display("FAIL wrap_own2 ack=%b owner=%0d want 00000100/2", bus.ack, bus.owner); end
    bus.req = '0;
    repeat (2) step();
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid_grant();
    pulse_reset();
    bus.req = 8'h10;
    step();
    n_checks++; if (bus.ack !== 8'h10) begin n_fail++; $display("FAIL midrst_grant got=%b want=00010000", bus.ack); end
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_checks++; if (bus.ack !== '0 || bus.owner_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_drop ack=%b valid=%b want 0/0", bus.ack, bus.owner_valid); end
    n_checks++; if (bus.bus_out !== '0 || bus.owner !== '0) begin n_fail++; $display("FAIL midrst_bus bus=%h owner=%0d want 0/0", bus.bus_out, bus.owner); end
    @(negedge clk);
    n_checks++; if (bus.timeout_err !== 1'b0 || bus.ack !== '0) begin n_fail++; $display("FAIL midrst_held ack=%b tout=%b want 0/0", bus.ack, bus.timeout_err); end
    reset   = 1'b0;
    bus.req = 8'h80;
    step();
    n_checks++; if (bus.ack !== 8'h80 || bus.owner !== 3'd7) begin n_fail++; $display("FAIL midrst_post ack=%b owner=%0d want 10000000/7", bus.ack, bus.owner); end
    bus.req = '0;
    repeat (2) step();
    $display("test_reset_mid_grant done");
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    pulse_reset();
    bus.req = 8'h08;
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < HM; i++) begin
        step();
        n_checks++; if (bus.ack !== 8'h08 || bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL tout_hold r=%0d i=%0d ack=%b tout=%b want 00001000/0", round, i, bus.ack, bus.timeout_err); end
      end
      step();
      n_checks++; if (bus.ack !== '0 || bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL tout_turn r=%0d ack=%b tout=%b want 0/1", round, bus.ack, bus.timeout_err); end
    end
    bus.req = '0;
    repeat (2) step();
    $display("test_timeout done");
  endtask
`else
  task automatic test_long_hold();
    pulse_reset();
    bus.req = 8'h01;
    for (int c = 0; c < 1000; c++) begin
      step();
      n_checks++; if (bus.ack !== 8'h01) begin n_fail++; $display("FAIL hold_ack cyc=%0d got=%b want=00000001", c, bus.ack); end
      n_checks++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL hold_tout cyc=%0d got=%b want=0", c, bus.timeout_err); end
    end
    bus.req = '0;
    repeat (2) step();
    $display("test_long_hold done");
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] r, prev_ack;
    pulse_reset();
    r = '0;
    prev_ack = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < N; d++) if ($urandom_range(5) == 0) r[d] = ~r[d];
      bus.req = r;
      randomize_buses();
      step();
      n_checks++; if (bus.ack !== exp_ack()) begin n_fail++; $display("FAIL rand_ack cyc=%0d got=%b want=%b", c, bus.ack, exp_ack()); end
      n_checks++; if (bus.owner_valid !== (m_busy != 0)) begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%b want=%0d", c, bus.owner_valid, m_busy); end
      if (m_busy != 0) begin
        n_checks++; if (bus.owner !== OW'(m_owner)) begin n_fail++; $display("FAIL rand_owner cyc=%0d got=%0d want=%0d", c, bus.owner, m_owner); end
      end
      n_checks++; if (bus.bus_out !== exp_bus()) begin n_fail++; $display("FAIL rand_bus cyc=%0d got=%h want=%h", c, bus.bus_out, exp_bus()); end
      n_checks++; if (bus.ctrl_out !== exp_ctrl()) begin n_fail++; $display("FAIL rand_ctrl cyc=%0d got=%h want=%h", c, bus.ctrl_out, exp_ctrl()); end
      n_checks++; if (bus.timeout_err !== (m_tout != 0)) begin n_fail++; $display("FAIL rand_tout cyc=%0d got=%b want=%0d", c, bus.timeout_err, m_tout); end
      n_checks++; if ($countones(bus.ack) > 1) begin n_fail++; $display("FAIL rand_onehot cyc=%0d got=%b want<=1 bit", c, bus.ack); end
      if (prev_ack == '0 && bus.ack != '0) begin
        n_checks++; if ((bus.ack & ~r) != '0) begin n_fail++; $display("FAIL rand_unreq cyc=%0d ack=%b req=%b want ack within req", c, bus.ack, r); end
      end
      prev_ack = bus.ack;
    end
    bus.req = '0;
    repeat (2) step();
    $display("test_random done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.req     = '0;
    bus.bus_in  = '0;
    bus.ctrl_in = '0;
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_reset_mid_grant();
`ifdef BUS_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_hold();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
